// File: rtl/npc_pkg.sv
// Shared core definitions: data width, RV32M multiply op encodings and the
// multiplier's FSM state type.
package npc_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } mul_state_t;

endpackage

// File: rtl/iter_mul_adder.sv
// Combinational WIDTH-bit adder shared with the ALU; the multiplier borrows it
// for the add step of each shift-add iteration.
module iter_mul_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             en,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // When disabled the adder passes operand a straight through.
    always_comb begin
        if (en) begin
            {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        end else begin
            {cout, sum} = {1'b0, a};
        end
    end

endmodule

// File: rtl/iter_mul.sv
// Multi-cycle shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Optional MUL_EARLY_EXIT_EN: leave BUSY once the remaining multiplier bits are zero.
module iter_mul
    import npc_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mul_state_t         state;
    mul_state_t         state_next;

    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   result_q;
    logic [1:0]         op_q;
    logic               neg;
    logic [CNT_W-1:0]   cnt;

    logic               a_signed;
    logic               b_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic               last_step;
    logic [2*WIDTH-1:0] prod_adj;
    logic [2*WIDTH-1:0] prod_fix;

`ifdef MUL_EARLY_EXIT_EN
    logic [WIDTH-1:0]   rem_mask;
    logic [CNT_W-1:0]   shamt;
`endif

    // Magnitudes of the operands; |INT_MIN| still fits unsigned in WIDTH bits.
    always_comb begin
        a_signed = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
        b_signed = (op == MUL_OP_MULH);
        a_neg    = a_signed && a[WIDTH-1];
        b_neg    = b_signed && b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
    end

    assign add_b = lo[0] ? mcand : '0;

    iter_mul_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (hi),
        .b    (add_b),
        .cin  (1'b0),
        .en   (1'b1),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
`ifdef MUL_EARLY_EXIT_EN
        // Bits still to be consumed after this step are lo[WIDTH-1-cnt:1].
        rem_mask  = {WIDTH{1'b1}} >> (cnt + CNT_W'(1));
        last_step = (cnt == CNT_W'(WIDTH - 1)) || (((lo >> 1) & rem_mask) == '0);
        shamt     = CNT_W'(WIDTH) - cnt;
        prod_adj  = {hi, lo} >> shamt;
`else
        last_step = (cnt == CNT_W'(WIDTH - 1));
        prod_adj  = {hi, lo};
`endif
        prod_fix  = neg ? -prod_adj : prod_adj;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // flush beats both a new op and a result handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid && !flush) state_next = BUSY;
            BUSY: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = FIX;
                end
            end
            FIX:  state_next = flush ? IDLE : DONE;
            DONE: if (flush || out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            mcand    <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            op_q     <= MUL_OP_MUL;
            result_q <= '0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= a_mag;
                        hi    <= '0;
                        lo    <= b_mag;
                        cnt   <= '0;
                        neg   <= a_neg ^ b_neg;
                        op_q  <= op;
                    end
                end
                BUSY: begin
                    hi  <= {cout, sum[WIDTH-1:1]};
                    lo  <= {sum[0], lo[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    {hi, lo} <= prod_fix;
                    result_q <= (op_q == MUL_OP_MUL) ? prod_fix[WIDTH-1:0]
                                                     : prod_fix[2*WIDTH-1:WIDTH];
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_iter_mul.sv
// Scoreboard bench for iter_mul: directed vectors push expected results, a
// negedge monitor pops and compares on every result handshake.
module tb_iter_mul;
    import npc_pkg::*;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    vec_t        vecs[0:7];

    iter_mul #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Issues one op; the accepting edge is the posedge this task waits for.
    task automatic applyStimulus(input logic [1:0] vop, input logic [31:0] va,
                                 input logic [31:0] vb, input logic [31:0] vres,
                                 input bit push);
        int n = 0;
        while (!in_ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
        op       = vop;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        if (push) exp_q.push_back(vres);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Latency counts the accepting edge as 1 through the edge that raises out_valid.
    task automatic waitDone(output int lat);
        lat = 1;
        while (!out_valid && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_out_valid actual=timeout required=out_valid");
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!in_ready && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("return_to_idle", {31'b0, in_ready}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output actual=0x%08h required=no_output", result);
            end else begin
                checkOutput("scoreboard_result", result, exp_q.pop_front());
            end
        end
    end

    initial begin
        int  lat;
        bit  seen;
        int  n;
        int  exp_lat_short;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = MUL_OP_MUL;
        a         = '0;
        b         = '0;

        vecs[0] = '{MUL_OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[1] = '{MUL_OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[2] = '{MUL_OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
        vecs[3] = '{MUL_OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[4] = '{MUL_OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[5] = '{MUL_OP_MULH,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
        vecs[6] = '{MUL_OP_MUL,    32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA};
        vecs[7] = '{MUL_OP_MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_reset", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;

`ifdef MUL_EARLY_EXIT_EN
        exp_lat_short = 5;
`else
        exp_lat_short = 34;
`endif
        applyStimulus(MUL_OP_MUL, 32'd7, 32'd6, 32'h0000002A, 1'b1);
        waitDone(lat);
        checkOutput("latency_mul_7x6", lat, exp_lat_short);
        @(posedge clk);
        #1;
        checkOutput("idle_after_handshake", {31'b0, in_ready}, 32'd1);
        checkOutput("out_valid_drops", {31'b0, out_valid}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, 1'b1);
            waitDone(lat);
            @(posedge clk);
            #1;
            waitIdle();
        end

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(MUL_OP_MUL, 32'd123, 32'd456, 32'h0000DB18, 1'b1);
        waitDone(lat);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_out_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("hold_result", result, 32'h0000DB18);
            checkOutput("hold_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_idle_next", {31'b0, in_ready}, 32'd1);
        checkOutput("bp_out_valid_low", {31'b0, out_valid}, 32'd0);

        $display("[TB] flush in BUSY");
        applyStimulus(MUL_OP_MUL, 32'h00001234, 32'h00005678, 32'h0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_to_idle", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("flush_no_out_valid", {31'b0, seen}, 32'd0);
        applyStimulus(MUL_OP_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, 1'b1);
        waitDone(lat);
        @(posedge clk);
        #1;
        waitIdle();

        $display("[TB] reset in FIX");
        applyStimulus(MUL_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0);
        repeat (32) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

`ifdef MUL_EARLY_EXIT_EN
        exp_lat_short = 3;
`else
        exp_lat_short = 34;
`endif
        applyStimulus(MUL_OP_MUL, 32'd5, 32'd1, 32'h00000005, 1'b1);
        waitDone(lat);
        checkOutput("latency_mul_5x1", lat, exp_lat_short);
        @(posedge clk);
        #1;
        waitIdle();
        applyStimulus(MUL_OP_MUL, 32'd3, 32'h80000000, 32'h80000000, 1'b1);
        waitDone(lat);
        checkOutput("latency_mul_3x80000000", lat, 34);
        @(posedge clk);
        #1;
        waitIdle();

        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
